trainer_truth_table_sequencer: RTL and testbench

TRAINER_TRUTH_TABLE_SEQUENCER -- requirements
Module: trainer_truth_table_sequencer

---
 rtl/trainer_truth_table_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_trainer_truth_table_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/trainer_truth_table_sequencer.sv
// Purpose : sweeps a/b through 00,01,10,11 into a downstream gate unit, captures
//           the returned y_in as a 4-bit truth table and grades it against gate_sel.
// Latency : 4*(SETTLE_CYCLES+2)+1 cycles from leaving IDLE to the done pulse.
// Backpressure: none; start edges are ignored while busy, ena=0 aborts a sweep.
// Ports   : clk/rst (async active-high), ena, start (async level), gate_sel[2:0], y_in;
//           a_out/b_out/sel_out[2:0] to the gate unit, busy, done (1-cycle pulse),
//           table_out[3:0] (bit index {a,b}), pass/fail (verdict of last sweep).
module trainer_truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic [2:0] sel_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass,
  output logic       fail
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, CHECK} state_t;

  state_t     state_q, state_d;
  logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic       rdy_q, rdy_d, armed_q, armed_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d;
  logic       pass_q, pass_d, fail_q, fail_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] table_q, table_d;
  logic [3:0] exp_table;
  logic [1:0] idx_nxt;
  logic       start_edge;

  // Expected truth tables, bit index {a,b}.
  always_comb begin
    exp_table = 4'b0000;
    case (sel_q)
      3'b000:  exp_table = 4'b1000;
      3'b001:  exp_table = 4'b1110;
      3'b010:  exp_table = 4'b0011;
      3'b011:  exp_table = 4'b0111;
      3'b100:  exp_table = 4'b0001;
      3'b101:  exp_table = 4'b0110;
      3'b110:  exp_table = 4'b1001;
      default: exp_table = 4'b0000;
    endcase
  end

  // armed_q only sets once the synchronised start has been seen low after reset,
  // so a button held through reset release cannot launch a sweep.
  assign start_edge = armed_q & sync2_q & ~prev_q;
  assign idx_nxt    = idx_q + 2'd1;

  always_comb begin
    state_d = state_q;
    sync1_d = start;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    rdy_d   = 1'b1;
    armed_d = armed_q | (rdy_q & ~sync1_q);
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    sel_d   = sel_q;
    table_d = table_q;

    case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (ena && start_edge) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          table_d = 4'b0000;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          sel_d   = gate_sel;
        end
      end
      DRIVE: begin
        state_d = SETTLE;
        cnt_d   = 4'(SETTLE_CYCLES - 1);
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SAMPLE: begin
        table_d[idx_q] = y_in;
        if (idx_q == 2'd3) begin
          state_d = CHECK;
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_nxt;
          a_d     = idx_nxt[1];
          b_d     = idx_nxt[0];
        end
      end
      CHECK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        // Reserved code 111 always fails, whatever table came back.
        pass_d  = (sel_q != 3'b111) && (table_q == exp_table);
        fail_d  = ~((sel_q != 3'b111) && (table_q == exp_table));
      end
      default: state_d = IDLE;
    endcase

    // Dropping ena mid-sweep abandons it silently and wipes the partial result.
    if (state_q != IDLE && !ena) begin
      state_d = IDLE;
      done_d  = 1'b0;
      a_d     = 1'b0;
      b_d     = 1'b0;
      cnt_d   = 4'd0;
      table_d = 4'b0000;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      sel_q   <= 3'b000;
      table_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      rdy_q   <= rdy_d;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      sel_q   <= sel_d;
      table_q <= table_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign sel_out   = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_trainer_truth_table_sequencer.sv
// Purpose : scoreboard bench for trainer_truth_table_sequencer with a behavioural gate unit.
// Latency : expects done 17 cycles after busy rises (default SETTLE_CYCLES).
// Backpressure: n/a; the monitor pops one expected verdict per done pulse.
module tb_trainer_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, start, y_in;
  logic [2:0] gate_sel;
  logic       a_out, b_out, busy, done, pass, fail;
  logic [2:0] sel_out;
  logic [3:0] table_out;

  typedef struct packed {
    logic [3:0] tbl;
    logic       p;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   start_cyc = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;
  int   y_mode = 0;  // 0: correct gate, 1: stuck at 0, 2: a&b regardless of code

  trainer_truth_table_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .gate_sel(gate_sel), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .sel_out(sel_out), .busy(busy), .done(done),
    .table_out(table_out), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic gate_model(logic [2:0] s, logic a, logic b);
    case (s)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  assign y_in = (y_mode == 0) ? gate_model(sel_out, a_out, b_out) :
                (y_mode == 1) ? 1'b0 : (a_out & b_out);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one expected verdict consumed per done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy && !busy_prev) start_cyc = cyc;
    busy_prev = busy;
    if (done) begin
      if (done_prev) check("done_one_cycle", 32'(done_prev), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with no sweep expected at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("table_out", 32'(table_out), 32'(e.tbl));
        check("pass", 32'(pass), 32'(e.p));
        check("fail", 32'(fail), 32'(e.f));
        check("sweep_latency", 32'(cyc - start_cyc), 32'd17);
      end
    end
    done_prev = done;
  end

  task automatic press();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Returns at the first negedge where busy is high (sweep offset 0).
  task automatic wait_busy();
    int n = 0;
    @(negedge clk);
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic push(logic [3:0] t, logic p, logic f);
    exp_t e;
    e.tbl = t;
    e.p   = p;
    e.f   = f;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    rst = 1'b1; ena = 1'b1; start = 1'b0; gate_sel = 3'd0;
    #12;
    check("reset_outputs", {a_out, b_out, sel_out, busy, done, table_out, pass, fail}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (4) @(negedge clk);

    // AND gate, correct unit: operand stepping, hold in IDLE.
    gate_sel = 3'd0; y_mode = 0;
    push(4'b1000, 1'b1, 1'b0);
    press();
    wait_busy();
    check("sel_latched", 32'(sel_out), 32'd0);
    check("ab_vec0", 32'({a_out, b_out}), 32'd0);
    for (int k = 1; k < 4; k++) begin
      repeat (4) @(negedge clk);
      check("ab_vec", 32'({a_out, b_out}), 32'(k));
    end
    repeat (4) @(negedge clk);
    check("check_state_busy_ab", 32'({busy, a_out, b_out}), 32'b100);
    wait_done();
    repeat (5) @(negedge clk);
    check("hold_in_idle", 32'({table_out, pass, fail, busy}), 32'b1000_1_0_0);

    // XOR with y stuck at 0.
    gate_sel = 3'd5; y_mode = 1;
    push(4'b0000, 1'b0, 1'b1);
    press();
    wait_busy();
    wait_done();

    // Reserved code with a plausible-looking AND response.
    gate_sel = 3'd7; y_mode = 2;
    push(4'b1000, 1'b0, 1'b1);
    press();
    wait_busy();
    wait_done();

    // Second press mid-sweep is ignored; gate_sel changes do not disturb sel_out.
    gate_sel = 3'd0; y_mode = 0;
    push(4'b1000, 1'b1, 1'b0);
    press();
    wait_busy();
    gate_sel = 3'd3;
    repeat (3) @(negedge clk);
    press();
    check("sel_stable", 32'(sel_out), 32'd0);
    wait_done();
    hits = 0;
    repeat (25) begin
      @(negedge clk);
      if (busy) hits++;
    end
    check("no_restart", 32'(hits), 32'd0);

    // ena dropped at cycle 8 with OR gate: partial table seen, then wiped.
    gate_sel = 3'd1; y_mode = 0;
    press();
    wait_busy();
    repeat (8) @(negedge clk);
    check("partial_table", 32'(table_out), 32'b0010);
    ena = 1'b0;
    @(negedge clk);
    check("abort_state", 32'({busy, table_out, pass, fail, a_out, b_out}), 32'd0);
    ena = 1'b1;
    repeat (30) @(negedge clk);

    // Asynchronous reset mid-sweep with start held through release.
    gate_sel = 3'd6; y_mode = 0;
    press();
    wait_busy();
    repeat (9) @(negedge clk);
    start = 1'b1;
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", {a_out, b_out, sel_out, busy, done, table_out, pass, fail}, 0);
    @(negedge clk) rst = 1'b0;
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) hits++;
    end
    check("held_start_no_sweep", 32'(hits), 32'd0);
    start = 1'b0;
    repeat (5) @(negedge clk);
    push(4'b1001, 1'b1, 1'b0);
    press();
    wait_busy();
    wait_done();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
